// File: rtl/cpu_pkg.sv
// Shared core definitions: default data width, the hard-wired zero register
// index and the register index type for the default register count.
package cpu_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 16;
  localparam int ZERO_REG      = 0;

  typedef logic [$clog2(NREGS_DEFAULT)-1:0] reg_idx_t;

endpackage

// File: rtl/sb_scoreboard.sv
// Per-register busy scoreboard: issue reserves a destination, write-back
// releases it, and RAW/WAW hazards raise iss_stall.
module sb_scoreboard
  import cpu_pkg::*;
#(
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int ADDR_W = $clog2(NREGS),
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              iss_rd_en,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  output logic              iss_stall,
  output logic [NREGS-1:0]  busy,
  output logic [ADDR_W:0]   pending
);

  localparam int CNT_W = ADDR_W + 1;

  logic [NREGS-1:0] busy_q, busy_d, eff_busy;
  logic [CNT_W-1:0] pending_q, pending_d;
  logic             hazard;
  logic             accept;

  // A register being written back this cycle is already resolved when forwarding.
  always_comb begin
    eff_busy = busy_q;
    if ((BYPASS != 0) && wb_en) eff_busy[wb_addr] = 1'b0;
    hazard = eff_busy[rs1_addr] | eff_busy[rs2_addr] | (iss_rd_en & eff_busy[iss_rd]);
    iss_stall = iss_valid & hazard;
    accept    = iss_valid & ~hazard;
  end

  // Release first so a same-cycle reservation of the same index wins.
  always_comb begin
    busy_d = busy_q;
    if (wb_en) busy_d[wb_addr] = 1'b0;
    if (accept && iss_rd_en) busy_d[iss_rd] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
    pending_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      pending_d = pending_d + CNT_W'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy_q    <= '0;
      pending_q <= '0;
    end else begin
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

  assign busy    = busy_q;
  assign pending = pending_q;

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write-back port,
// hard-wired zero register, optional write-back forwarding and a busy scoreboard.
module reg_file_sb
  import cpu_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int NREGS  = NREGS_DEFAULT,
  parameter int ADDR_W = $clog2(NREGS),
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs1_addr,
  output logic [XLEN-1:0]   rs1_data,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs2_data,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              iss_rd_en,
  output logic              iss_stall,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [XLEN-1:0]   wb_data,
  output logic [NREGS-1:0]  busy,
  output logic [ADDR_W:0]   pending
);

  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic            wb_live;

  assign wb_live = wb_en && (wb_addr != ZERO_IDX);

  always_comb begin
    regs_d = regs_q;
    if (wb_live) regs_d[wb_addr] = wb_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) regs_q <= '{default: '0};
    else        regs_q <= regs_d;
  end

  // x0 reads as zero regardless of storage; forwarding overrides the array.
  always_comb begin
    rs1_data = (rs1_addr == ZERO_IDX) ? '0 : regs_q[rs1_addr];
    rs2_data = (rs2_addr == ZERO_IDX) ? '0 : regs_q[rs2_addr];
    if ((BYPASS != 0) && wb_live && (wb_addr == rs1_addr)) rs1_data = wb_data;
    if ((BYPASS != 0) && wb_live && (wb_addr == rs2_addr)) rs2_data = wb_data;
  end

  sb_scoreboard #(
    .NREGS  (NREGS),
    .ADDR_W (ADDR_W),
    .BYPASS (BYPASS)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_rd_en (iss_rd_en),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .iss_stall (iss_stall),
    .busy      (busy),
    .pending   (pending)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb (XLEN=32, NREGS=16, BYPASS=1).
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rs1_addr, rs2_addr, iss_rd, wb_addr;
  logic [31:0] rs1_data, rs2_data, wb_data;
  logic        iss_valid, iss_rd_en, iss_stall, wb_en;
  logic [15:0] busy;
  logic [4:0]  pending;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_file_sb #(.XLEN(32), .NREGS(16), .BYPASS(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .rs1_addr  (rs1_addr),
    .rs1_data  (rs1_data),
    .rs2_addr  (rs2_addr),
    .rs2_data  (rs2_data),
    .iss_valid (iss_valid),
    .iss_rd    (iss_rd),
    .iss_rd_en (iss_rd_en),
    .iss_stall (iss_stall),
    .wb_en     (wb_en),
    .wb_addr   (wb_addr),
    .wb_data   (wb_data),
    .busy      (busy),
    .pending   (pending)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0; rs1_addr = '0; rs2_addr = '0; iss_valid = 1'b0; iss_rd = '0;
    iss_rd_en = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    #3;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_rs1", rs1_data, 32'h0);
    chk("rst_stall", 32'(iss_stall), 32'h0);
    @(negedge clk); reset = 1'b1;

    // Write x5, reserve x7, then reset between edges
    tick();
    wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'hDEADBEEF;
    tick();
    wb_en = 1'b0; rs1_addr = 4'd5;
    #1 chk("x5_written", rs1_data, 32'hDEADBEEF);
    iss_valid = 1'b1; iss_rd = 4'd7; iss_rd_en = 1'b1;
    #1 chk("x7_issue_nostall", 32'(iss_stall), 32'h0);
    tick();
    iss_valid = 1'b0; iss_rd_en = 1'b0;
    #1 chk("x7_busy", 32'(busy), 32'h0080);
    chk("x7_pending", 32'(pending), 32'd1);
    reset = 1'b0;
    #1 chk("midrst_rs1", rs1_data, 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_pending", 32'(pending), 32'h0);
    @(negedge clk); reset = 1'b1;

    // x0 protection
    tick();
    wb_en = 1'b1; wb_addr = 4'd0; wb_data = 32'hFFFFFFFF; rs1_addr = 4'd0;
    #1 chk("x0_wb_nobypass", rs1_data, 32'h0);
    tick();
    wb_en = 1'b0; iss_valid = 1'b1; iss_rd = 4'd0; iss_rd_en = 1'b1;
    #1 chk("x0_issue_nostall", 32'(iss_stall), 32'h0);
    tick();
    iss_valid = 1'b0; iss_rd_en = 1'b0;
    #1 chk("x0_read", rs1_data, 32'h0);
    chk("x0_busy", 32'(busy), 32'h0);
    chk("x0_pending", 32'(pending), 32'h0);

    // Same-cycle forwarding of x3 to both ports
    rs1_addr = 4'd3; rs2_addr = 4'd3;
    #1 chk("x3_before", rs1_data, 32'h0);
    wb_en = 1'b1; wb_addr = 4'd3; wb_data = 32'h12345678;
    #1 chk("bypass_rs1", rs1_data, 32'h12345678);
    chk("bypass_rs2", rs2_data, 32'h12345678);
    tick();
    wb_en = 1'b0;
    #1 chk("x3_stored", rs2_data, 32'h12345678);
    chk("x3_wb_nonbusy_pending", 32'(pending), 32'h0);

    // RAW on x4
    rs1_addr = 4'd0; rs2_addr = 4'd0;
    iss_valid = 1'b1; iss_rd = 4'd4; iss_rd_en = 1'b1;
    tick();
    iss_rd_en = 1'b0; rs1_addr = 4'd4;
    #1 chk("raw_stall", 32'(iss_stall), 32'h1);
    chk("raw_pending", 32'(pending), 32'd1);
    tick();
    #1 chk("raw_stall_hold", 32'(iss_stall), 32'h1);
    wb_en = 1'b1; wb_addr = 4'd4; wb_data = 32'h0000A5A5;
    #1 chk("raw_wb_nostall", 32'(iss_stall), 32'h0);
    chk("raw_wb_fwd", rs1_data, 32'h0000A5A5);
    tick();
    wb_en = 1'b0; iss_valid = 1'b0; rs1_addr = 4'd0;
    #1 chk("raw_busy_clear", 32'(busy), 32'h0);

    // WAW on x6 resolved by a same-cycle write-back
    iss_valid = 1'b1; iss_rd = 4'd6; iss_rd_en = 1'b1;
    tick();
    iss_valid = 1'b0;
    #1 chk("x6_busy", 32'(busy), 32'h0040);
    iss_valid = 1'b1;
    #1 chk("waw_stall", 32'(iss_stall), 32'h1);
    wb_en = 1'b1; wb_addr = 4'd6; wb_data = 32'h00000066;
    #1 chk("waw_wb_nostall", 32'(iss_stall), 32'h0);
    tick();
    wb_en = 1'b0; iss_valid = 1'b0; iss_rd_en = 1'b0; rs1_addr = 4'd6;
    #1 chk("waw_busy_kept", 32'(busy), 32'h0040);
    chk("waw_pending", 32'(pending), 32'd1);
    chk("waw_data", rs1_data, 32'h00000066);
    wb_en = 1'b1; wb_addr = 4'd6;
    tick();
    wb_en = 1'b0;
    #1 chk("x6_release", 32'(pending), 32'd0);

    // Fill every reservable register, then drain
    iss_rd_en = 1'b1; rs1_addr = 4'd0;
    for (int i = 1; i < 16; i++) begin
      iss_valid = 1'b1; iss_rd = 4'(i);
      tick();
      chk("fill_pending", 32'(pending), 32'(i));
    end
    iss_valid = 1'b0; iss_rd_en = 1'b0;
    #1 chk("fill_busy", 32'(busy), 32'hFFFE);
    for (int i = 1; i < 16; i++) begin
      wb_en = 1'b1; wb_addr = 4'(i); wb_data = 32'(i * 32'h11);
      tick();
      chk("drain_pending", 32'(pending), 32'(15 - i));
    end
    wb_en = 1'b0; rs2_addr = 4'd9;
    #1 chk("drain_busy", 32'(busy), 32'h0);
    chk("drain_x9", rs2_data, 32'h00000099);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
